// File: rtl/half_adder_mux_pkg.sv
// Shared constants for the mux-based half adder: truth-table vectors fed to the
// per-lane 4:1 muxes and the carry-count width helper.
package ha_mux_pkg;

    localparam logic [3:0] SUM_TT   = 4'b0110;
    localparam logic [3:0] CARRY_TT = 4'b1000;

    // Bits needed to hold a count from 0 to width inclusive.
    function automatic int carryCntWidth(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/half_adder_mux_mux4_1.sv
// Combinational 4:1 multiplexer, y = d[sel].
module mux4_1 (
    input  logic [3:0] d,
    input  logic [1:0] sel,
    output logic       y
);

    assign y = d[sel];

endmodule

// File: rtl/half_adder_mux.sv
// Registered multi-lane half adder; each lane's sum/carry is a mux lookup on {a,b}.
// Optional self-check against gate logic is enabled by defining HA_SELFCHECK_EN.
module half_adder_mux
    import ha_mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
    output logic                                out_valid,
    output logic [WIDTH-1:0]                    sum,
    output logic [WIDTH-1:0]                    carry,
    output logic                                carry_any,
    output logic [carryCntWidth(WIDTH)-1:0]     carry_cnt
`ifdef HA_SELFCHECK_EN
    ,
    output logic                                chk_err
`endif
);

    localparam int CNT_W = carryCntWidth(WIDTH);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_carry;
    logic             w_carry_any;
    logic [CNT_W-1:0] w_carry_cnt;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] r_carry;
    logic             r_carry_any;
    logic [CNT_W-1:0] r_carry_cnt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [1:0] w_sel;
        assign w_sel = {a[i], b[i]};

        mux4_1 u_sum (
            .d   (SUM_TT),
            .sel (w_sel),
            .y   (w_sum[i])
        );

        mux4_1 u_carry (
            .d   (CARRY_TT),
            .sel (w_sel),
            .y   (w_carry[i])
        );
    end

    // Summaries come from the same-cycle mux carries so they always agree with carry.
    always_comb begin
        w_carry_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry_cnt = w_carry_cnt + CNT_W'(w_carry[i]);
        end
    end

    assign w_carry_any = |w_carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_carry     <= '0;
            r_carry_any <= 1'b0;
            r_carry_cnt <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_sum       <= w_sum;
                r_carry     <= w_carry;
                r_carry_any <= w_carry_any;
                r_carry_cnt <= w_carry_cnt;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign carry     = r_carry;
    assign carry_any = r_carry_any;
    assign carry_cnt = r_carry_cnt;

`ifdef HA_SELFCHECK_EN
    logic w_mismatch;
    logic r_chk_err;

    assign w_mismatch = in_valid && ((w_sum != (a ^ b)) || (w_carry != (a & b)));

    // Sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_chk_err <= 1'b0;
        end else if (w_mismatch) begin
            r_chk_err <= 1'b1;
        end
    end

    assign chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_half_adder_mux.sv
// Directed table-driven bench for half_adder_mux at WIDTH=1 and WIDTH=4.
// Exercises the chk_err path too when HA_SELFCHECK_EN is defined.
module tb_half_adder_mux;

    typedef struct {
        logic       rstN;
        logic       valid;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] expSum;
        logic [3:0] expCarry;
        logic       expAny;
        logic [2:0] expCnt;
        logic       expValid;
    } vec_t;

    logic       clk = 1'b0;
    int         checks = 0;
    int         errors = 0;

    logic       rst1N, valid1, a1, b1;
    logic       outValid1, sum1, carry1, carryAny1;
    logic [0:0] carryCnt1;

    logic       rst4N, valid4;
    logic [3:0] a4, b4;
    logic       outValid4, carryAny4;
    logic [3:0] sum4, carry4;
    logic [2:0] carryCnt4;

`ifdef HA_SELFCHECK_EN
    logic       chkErr1, chkErr4;
`endif

    always #5 clk = ~clk;

    half_adder_mux #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst1N),
        .in_valid  (valid1),
        .a         (a1),
        .b         (b1),
        .out_valid (outValid1),
        .sum       (sum1),
        .carry     (carry1),
        .carry_any (carryAny1),
        .carry_cnt (carryCnt1)
`ifdef HA_SELFCHECK_EN
        ,
        .chk_err   (chkErr1)
`endif
    );

    half_adder_mux #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst4N),
        .in_valid  (valid4),
        .a         (a4),
        .b         (b4),
        .out_valid (outValid4),
        .sum       (sum4),
        .carry     (carry4),
        .carry_any (carryAny4),
        .carry_cnt (carryCnt4)
`ifdef HA_SELFCHECK_EN
        ,
        .chk_err   (chkErr4)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one row into the selected DUT, clock it, then check one cycle later.
    task automatic applyStimulus(input int which, input int idx, input vec_t v);
        if (which == 1) begin
            rst1N  = v.rstN;
            valid1 = v.valid;
            a1     = v.a[0];
            b1     = v.b[0];
        end else begin
            rst4N  = v.rstN;
            valid4 = v.valid;
            a4     = v.a;
            b4     = v.b;
        end
        @(posedge clk);
        #1;
        if (which == 1) begin
            checkOutput($sformatf("w1[%0d].out_valid", idx), {31'b0, outValid1}, {31'b0, v.expValid});
            checkOutput($sformatf("w1[%0d].sum", idx), {31'b0, sum1}, {31'b0, v.expSum[0]});
            checkOutput($sformatf("w1[%0d].carry", idx), {31'b0, carry1}, {31'b0, v.expCarry[0]});
            checkOutput($sformatf("w1[%0d].carry_any", idx), {31'b0, carryAny1}, {31'b0, v.expAny});
            checkOutput($sformatf("w1[%0d].carry_cnt", idx), {31'b0, carryCnt1}, {31'b0, v.expCnt[0]});
        end else begin
            checkOutput($sformatf("w4[%0d].out_valid", idx), {31'b0, outValid4}, {31'b0, v.expValid});
            checkOutput($sformatf("w4[%0d].sum", idx), {28'b0, sum4}, {28'b0, v.expSum});
            checkOutput($sformatf("w4[%0d].carry", idx), {28'b0, carry4}, {28'b0, v.expCarry});
            checkOutput($sformatf("w4[%0d].carry_any", idx), {31'b0, carryAny4}, {31'b0, v.expAny});
            checkOutput($sformatf("w4[%0d].carry_cnt", idx), {29'b0, carryCnt4}, {29'b0, v.expCnt});
        end
    endtask

    vec_t tbl1[9];
    vec_t tbl4[14];

    initial begin
        // rstN valid a b | sum carry any cnt out_valid
        tbl1[0] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};
        tbl1[1] = '{1'b0, 1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};
        tbl1[2] = '{1'b1, 1'b0, 4'h1, 4'h1, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};
        tbl1[3] = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1};
        tbl1[4] = '{1'b1, 1'b1, 4'h0, 4'h1, 4'h1, 4'h0, 1'b0, 3'd0, 1'b1};
        tbl1[5] = '{1'b1, 1'b1, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0, 3'd0, 1'b1};
        tbl1[6] = '{1'b1, 1'b1, 4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 3'd1, 1'b1};
        tbl1[7] = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h1, 1'b1, 3'd1, 1'b0};
        tbl1[8] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};

        tbl4[0]  = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};
        tbl4[1]  = '{1'b0, 1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};
        tbl4[2]  = '{1'b1, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};
        tbl4[3]  = '{1'b1, 1'b1, 4'hD, 4'hB, 4'h6, 4'h9, 1'b1, 3'd2, 1'b1};
        tbl4[4]  = '{1'b1, 1'b1, 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 3'd4, 1'b1};
        tbl4[5]  = '{1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1, 3'd4, 1'b0};
        tbl4[6]  = '{1'b1, 1'b1, 4'h5, 4'h3, 4'h6, 4'h1, 1'b1, 3'd1, 1'b1};
        tbl4[7]  = '{1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b1};
        tbl4[8]  = '{1'b1, 1'b1, 4'hA, 4'h5, 4'hF, 4'h0, 1'b0, 3'd0, 1'b1};
        tbl4[9]  = '{1'b1, 1'b1, 4'hC, 4'hC, 4'h0, 4'hC, 1'b1, 3'd2, 1'b1};
        tbl4[10] = '{1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 3'd0, 1'b0};
        tbl4[11] = '{1'b1, 1'b1, 4'h1, 4'h0, 4'h1, 4'h0, 1'b0, 3'd0, 1'b1};
        tbl4[12] = '{1'b1, 1'b1, 4'h7, 4'h7, 4'h0, 4'h7, 1'b1, 3'd3, 1'b1};
        tbl4[13] = '{1'b1, 1'b0, 4'bxxxx, 4'bxxxx, 4'h0, 4'h7, 1'b1, 3'd3, 1'b0};

        rst1N = 1'b0; valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        rst4N = 1'b0; valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, i, tbl1[i]);
        end
        for (int i = 0; i < 14; i++) begin
            applyStimulus(4, i, tbl4[i]);
        end

`ifdef HA_SELFCHECK_EN
        rst4N = 1'b0; valid4 = 1'b0;
        @(posedge clk);
        #1;
        rst4N = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            valid4 = 1'($urandom_range(0, 1));
            a4     = 4'($urandom_range(0, 15));
            b4     = 4'($urandom_range(0, 15));
            @(posedge clk);
            #1;
        end
        checkOutput("chk_err after random", {31'b0, chkErr4}, 32'd0);

        // Corrupt the mux sums for one valid cycle: true sum of F+0 is F.
        valid4 = 1'b1; a4 = 4'hF; b4 = 4'h0;
        force dut4.w_sum = 4'h0;
        @(posedge clk);
        #1;
        release dut4.w_sum;
        checkOutput("chk_err after fault", {31'b0, chkErr4}, 32'd1);
        a4 = 4'h3; b4 = 4'h1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("chk_err sticky", {31'b0, chkErr4}, 32'd1);
        rst4N = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("chk_err reset", {31'b0, chkErr4}, 32'd0);
        rst4N = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/half_adder_mux.md
Name: half_adder_mux

Overview:
- Registered, multi-lane half adder. Each lane's sum and carry come from a 4:1 multiplexer, not from XOR/AND gates.
- Select = {a,b}. Data inputs are constant truth-table vectors.
- Arithmetic leaf cell for datapath blocks that need registered per-bit sum/carry plus a carry summary.
- Single clock domain. Synchronous, active-low reset.

Parameters:
- WIDTH, 1, number of independent half-adder lanes (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- in_valid  input  1  a/b valid this cycle.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- out_valid  output  1  registered copy of in_valid.
- sum  output  WIDTH  per-lane sum, registered.
- carry  output  WIDTH  per-lane carry, registered.
- carry_any  output  1  OR of all carry bits, registered.
- carry_cnt  output  $clog2(WIDTH+1)  number of lanes with carry=1, registered.

Behaviour:
- One clock domain; reset is synchronous and active-low (rst_n, sampled on rising clk).
- Per-lane mux, with sel = {a[i], b[i]} (a is the MSB):
  - sum[i] = SUM_TT[sel], SUM_TT = 4'b0110.
  - carry[i] = CARRY_TT[sel], CARRY_TT = 4'b1000.
  - Resulting truth table: 00→s0 c0, 01→s1 c0, 10→s1 c0, 11→s0 c1.
- Reset (rst_n=0 at a rising edge): out_valid=0, sum=0, carry=0, carry_any=0, carry_cnt=0. Reset takes priority over in_valid.
- Latency is exactly 1 cycle. If in_valid=1 at edge N, the results for that a/b appear after edge N and out_valid=1 for that cycle.
- If in_valid=0 at an edge: out_valid goes to 0, and sum/carry/carry_any/carry_cnt hold their previous values.
- Back-to-back valid inputs are accepted every cycle. There is no backpressure and no ready signal.
- carry_any and carry_cnt are computed from the same-cycle mux carries and registered in the same edge as carry, so they are always mutually consistent.
- carry_cnt range is 0..WIDTH. Its width guarantees no overflow; at WIDTH=1 it is 1 bit.
- If reset is asserted mid-stream, all outputs clear at that edge. The first valid input after deassertion produces a normal result one cycle later.
- X on a/b while in_valid=0 must not disturb the held outputs.

Optional Feature:
- Macro: HA_SELFCHECK_EN.
- Defined:
  - Adds output chk_err (1 bit).
  - On every edge with in_valid=1, each lane's mux result is compared against gate logic (a^b, a&b).
  - Any mismatch sets chk_err=1 on the next cycle. chk_err is sticky until rst_n=0, which clears it.
- Undefined: the chk_err port and the comparison logic are absent. All other behaviour is identical.

Decomposition:
- Package ha_mux_pkg holds:
  - SUM_TT (4'b0110) and CARRY_TT (4'b1000) as 4-bit localparams.
  - A function returning the carry count width from WIDTH.
- Sub-module mux4_1: combinational 4:1 mux, inputs d[3:0] and sel[1:0], output y = d[sel].
- Top instantiates 2×WIDTH mux4_1 instances via a generate loop, plus the output registers and carry reduction logic.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=1, b=1 → all outputs 0 during reset; out_valid=0 one cycle after release if in_valid=0.
- WIDTH=1 truth table, driving one valid input per cycle:
  - a=0,b=0 → sum=0, carry=0.
  - a=0,b=1 → sum=1, carry=0.
  - a=1,b=0 → sum=1, carry=0.
  - a=1,b=1 → sum=0, carry=1, carry_any=1, carry_cnt=1.
  - Each result appears exactly one cycle after its input.
- WIDTH=4, a=4'b1101, b=4'b1011, in_valid=1 → next cycle sum=4'b0110, carry=4'b1001, carry_any=1, carry_cnt=2, out_valid=1.
- Hold: valid a=4'hF, b=4'hF, then in_valid=0 with a=0, b=0 → sum=0, carry=4'hF held, carry_cnt=4, out_valid=0.
- Mid-stream reset: rst_n=0 while outputs are nonzero → all outputs 0 at that edge; the next valid a=1,b=0 gives sum=1 one cycle after reset release.
- HA_SELFCHECK_EN defined: random valid stimulus for 1000 cycles → chk_err stays 0; force one mux output wrong → chk_err=1 the next cycle and stays 1 until reset.
